// File: rtl/mem_seq.sv
// Load/store sequencer: accepts one byte/half/word/dword request, drives a word-aligned
// memory strobe with byte enables, and returns extended load data or an error code.
module mem_seq #(
  parameter int XLEN      = 32,
  parameter int TIMEOUT   = 16,
  parameter bit ALLOW_MIS = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [XLEN-1:0]     req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                rsp_valid,
  output logic [XLEN-1:0]     rsp_rdata,
  output logic [1:0]          rsp_err,
  output logic [XLEN-1:0]     mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [XLEN/8-1:0]   mem_be,
  output logic                mem_read,
  output logic                mem_write,
  input  logic [XLEN-1:0]     mem_rdata,
  input  logic                mem_resp
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = $clog2(TIMEOUT + 2);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t            state, state_nxt;
  logic [1:0]        err_p1, err_nxt;
  logic [CNT_W-1:0]  cnt_p1;
  logic [XLEN-1:0]   addr_p1;
  logic [XLEN-1:0]   wdata_p1;
  logic [XLEN-1:0]   rdata_p1;
  logic [1:0]        size_p1;
  logic              write_p1;
  logic              uns_p1;
  logic [OFF_W-1:0]  off;

  // Illegal size or (when checked) an address not aligned to the access size.
  function automatic logic req_bad(input logic [1:0] size, input logic [2:0] a);
    logic bad;
    bad = 1'b0;
    if (size == 2'b11 && XLEN != 64) bad = 1'b1;
    if (!ALLOW_MIS) begin
      case (size)
        2'b01:   bad = bad | a[0];
        2'b10:   bad = bad | (|a[1:0]);
        2'b11:   bad = bad | (|a[2:0]);
        default: bad = bad;
      endcase
    end
    return bad;
  endfunction

  function automatic logic [NB-1:0] lane_mask(input logic [1:0] size, input logic [OFF_W-1:0] o);
    logic [NB-1:0] m;
    case (size)
      2'b00:   m = NB'(1) << o;
      2'b01:   m = NB'(3) << o;
      2'b10:   m = NB'(15) << o;
      default: m = '1;
    endcase
    return m;
  endfunction

  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] raw, input logic [1:0] size,
                                               input logic uns);
    logic [XLEN-1:0] r;
    case (size)
      2'b00:   r = uns ? XLEN'(raw[7:0])  : XLEN'($signed(raw[7:0]));
      2'b01:   r = uns ? XLEN'(raw[15:0]) : XLEN'($signed(raw[15:0]));
      2'b10:   r = uns ? XLEN'(raw[31:0]) : XLEN'($signed(raw[31:0]));
      default: r = raw;
    endcase
    return r;
  endfunction

  assign off = addr_p1[OFF_W-1:0];

  always_comb begin
    state_nxt = state;
    err_nxt   = err_p1;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_bad(req_size, req_addr[2:0])) begin
            state_nxt = RESP;
            err_nxt   = 2'b01;
          end else begin
            state_nxt = REQ;
            err_nxt   = 2'b00;
          end
        end
      end
      REQ: begin
        // A response arriving in the expiry cycle still counts as success.
        if (mem_resp) begin
          state_nxt = RESP;
          err_nxt   = 2'b00;
        end else if (TIMEOUT != 0 && cnt_p1 == TO_LAST) begin
          state_nxt = RESP;
          err_nxt   = 2'b10;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      err_p1 <= 2'b00;
      cnt_p1 <= '0;
    end else begin
      state  <= state_nxt;
      err_p1 <= err_nxt;
      if (state == IDLE)     cnt_p1 <= '0;
      else if (state == REQ) cnt_p1 <= cnt_p1 + 1'b1;
    end
  end

  // Request capture / read data capture stage.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      addr_p1  <= req_addr;
      wdata_p1 <= req_wdata;
      size_p1  <= req_size;
      write_p1 <= req_write;
      uns_p1   <= req_unsigned;
    end
    if (state == REQ && mem_resp) rdata_p1 <= mem_rdata;
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 2'b00;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (state == REQ) begin
      mem_addr  = {addr_p1[XLEN-1:OFF_W], OFF_W'(0)};
      mem_wdata = wdata_p1 << {off, 3'b000};
      mem_be    = lane_mask(size_p1, off);
      mem_read  = !write_p1;
      mem_write = write_p1;
    end
    if (state == RESP) begin
      rsp_valid = 1'b1;
      rsp_err   = err_p1;
      if (err_p1 == 2'b00 && !write_p1)
        rsp_rdata = load_ext(rdata_p1 >> {off, 3'b000}, size_p1, uns_p1);
    end
  end

endmodule

// File: tb/tb_mem_seq.sv
// Randomized scoreboard bench for mem_seq (XLEN=32, TIMEOUT=4, misalignment checked).
module tb_mem_seq;
  localparam int XLEN    = 32;
  localparam int TIMEOUT = 4;

  logic              clk, rst;
  logic              req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]        req_size;
  logic [XLEN-1:0]   req_addr, req_wdata;
  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_rdata;
  logic [1:0]        rsp_err;
  logic [XLEN-1:0]   mem_addr, mem_wdata, mem_rdata;
  logic [XLEN/8-1:0] mem_be;
  logic              mem_read, mem_write, mem_resp;

  mem_seq #(.XLEN(XLEN), .TIMEOUT(TIMEOUT), .ALLOW_MIS(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
  } rsp_t;
  rsp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: plain byte arithmetic on the request.
  function automatic logic [1:0] m_err(input logic [1:0] size, input logic [31:0] addr);
    int n;
    if (size == 2'b11) return 2'b01;
    n = 1 << size;
    if (addr % n != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rdata, input logic [1:0] size,
                                         input logic uns, input logic [31:0] addr);
    logic [63:0] v;
    int bits;
    bits = 8 * (1 << size);
    v = (64'(rdata) >> (8 * (addr % 4))) & ((64'd1 << bits) - 1);
    if (!uns && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
    return v[31:0];
  endfunction

  always @(negedge clk) begin
    rsp_t e;
    if (!rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", rsp_err, e.err);
      end
    end
  end

  task automatic wait_ready();
    int waited;
    waited = 0;
    @(negedge clk);
    while (!req_ready) begin
      mem_resp = 1'($urandom_range(0, 1));
      waited++;
      if (waited > 20) begin
        $display("FAIL ready_timeout: got req_ready=0 expected 1");
        $fatal(1);
      end
      @(negedge clk);
    end
    mem_resp = 1'b0;
  endtask

  // d = strobe cycle on which mem_resp arrives; 0 or > TIMEOUT means never.
  task automatic do_txn(input logic wr, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int d);
    rsp_t        e;
    logic [1:0]  e_err;
    logic        to;
    int          kmax, off, n;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    wait_ready();
    e_err   = m_err(size, addr);
    to      = (d == 0 || d > TIMEOUT);
    e.err   = (e_err != 0) ? 2'b01 : (to ? 2'b10 : 2'b00);
    e.rdata = (e.err != 0 || wr) ? 32'h0 : m_load(rdata, size, uns, addr);
    exp_q.push_back(e);
    req_valid = 1'b1; req_write = wr; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    req_size = 2'($urandom_range(0, 3)); req_write = 1'($urandom_range(0, 1));
    if (e_err != 0) begin
      @(negedge clk);
      check("err_rsp_latency", rsp_valid, 1);
      check("err_no_strobe", {mem_read, mem_write}, 0);
      return;
    end
    off    = addr % 4;
    n      = 1 << size;
    exp_be = 4'(((1 << n) - 1) << off);
    exp_wd = wdata << (8 * off);
    kmax   = to ? TIMEOUT : d;
    for (int k = 1; k <= kmax; k++) begin
      @(negedge clk);
      check("mem_read", mem_read, !wr);
      check("mem_write", mem_write, wr);
      check("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
      check("mem_be", mem_be, exp_be);
      if (wr) check("mem_wdata", mem_wdata, exp_wd);
      if (!to && k == d) begin
        mem_resp = 1'b1;
        mem_rdata = rdata;
      end
    end
    @(posedge clk);
    #1;
    mem_resp = 1'b0;
    mem_rdata = $urandom;
    @(negedge clk);
    check("rsp_latency", rsp_valid, 1);
    check("strobes_dropped", {mem_read, mem_write}, 0);
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    int          dl;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;
    #2;
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_strobes", {mem_read, mem_write}, 0);
    check("rst_mem_be", mem_be, 0);
    check("rst_rsp_err", rsp_err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_txn(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 3);
    do_txn(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80FFFFFF, 1);
    do_txn(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80FFFFFF, 2);
    do_txn(1'b1, 2'b01, 1'b0, 32'h102, 32'h1234, 32'h0, 2);
    do_txn(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h12345678, 1);
    do_txn(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 32'h55AA55AA, 0);
    do_txn(1'b0, 2'b10, 1'b0, 32'h204, 32'h0, 32'hCAFEF00D, TIMEOUT);
    do_txn(1'b0, 2'b11, 1'b0, 32'h208, 32'h0, 32'h0, 1);
    do_txn(1'b0, 2'b01, 1'b0, 32'h20A, 32'h0, 32'h8001_7FFF, 1);

    // Reset during REQ: strobes drop asynchronously, no response follows.
    wait_ready();
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h300;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_mem_read", mem_read, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_strobe", mem_read, 0);
    check("async_rst_ready", req_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("post_rst_no_rsp", rsp_valid, 0);
    end

    for (int i = 0; i < 300; i++) begin
      sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0)
        case (sz)
          2'b01:   a[0] = 1'b0;
          2'b10:   a[1:0] = 2'b00;
          default: a = a;
        endcase
      dl = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TIMEOUT + 1);
      do_txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom, dl);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
